// File: rtl/shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// shift_add_multiplier
//
// Sequential unsigned N x N -> 2N multiplier using the classic shift-add
// algorithm. One partial product is folded in per BUSY cycle. The latency is
// fixed at N+1 edges from accept to out_valid, whatever the operand values.
//
// Ports
//   clk          : single clock, rising-edge
//   rst          : synchronous, active-high reset
//   in_valid     : operands present on a / b
//   in_ready     : block can accept operands (IDLE only)
//   a            : N-bit unsigned multiplicand
//   b            : N-bit unsigned multiplier
//   out_valid    : product holds a valid result (DONE only)
//   out_ready    : consumer accepts the product
//   product      : 2N-bit unsigned product a*b
//   o_dbg_state  : current FSM state, for observation only
//
// Handshake semantics (both ports): a transfer happens on a rising edge where
// valid and ready are both 1. Once a producer raises valid it holds the
// payload stable until that transfer. in_ready and out_valid are pure decodes
// of the registered state, so they never depend combinationally on the
// opposite side. The result transfer and the next operand accept never share
// an edge.
// ---------------------------------------------------------------------------
module shift_add_multiplier #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product,
    output logic [1:0]     o_dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [N:0] CNT_LAST = (N+1)'(N);
    localparam logic [N:0] CNT_ONE  = (N+1)'(1);

    logic [1:0]     r_state;
    logic [N-1:0]   r_mcand;
    logic [2*N-1:0] r_acc;
    logic [N:0]     r_cnt;

    logic [N:0]     w_addend;
    logic [N:0]     w_sum;
    logic [2*N-1:0] w_shift;

    // The sum is N+1 bits wide. The carry of all-ones + all-ones survives
    // and becomes the top bit of the accumulator after the shift.
    always_comb begin
        w_addend = r_acc[0] ? {1'b0, r_mcand} : '0;
        w_sum    = {1'b0, r_acc[2*N-1:N]} + w_addend;
        // {carry, upper sum, lower half} shifted right by one
        w_shift  = {w_sum, r_acc[N-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_mcand <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mcand <= a;
                        r_acc   <= {{N{1'b0}}, b};
                        r_cnt   <= '0;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // N compute cycles take the counter from 0 to N. The
                    // cycle that observes N only moves to DONE, which gives
                    // the fixed accept-to-valid latency of N+1 edges.
                    if (r_cnt == CNT_LAST) begin
                        r_state <= S_DONE;
                    end else begin
                        r_acc <= w_shift;
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign product     = r_acc;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_shift_add_multiplier.sv
module tb_shift_add_multiplier;

  localparam int N = 32;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] product;
  logic [1:0]     dbg_state;

  int tests;
  int fails;
  logic [2*N-1:0] exp_q[$];
  bit acc_seen;
  bit pop_seen;

  shift_add_multiplier #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .product     (product),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2*N-1:0] obs, input logic [2*N-1:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock cycle. Inputs are already set (just after the previous edge);
  // the handshakes that the coming edge will complete are evaluated here,
  // feeding the scoreboard, then time advances to 1 unit past the edge.
  task automatic cycle();
    logic [2*N-1:0] expv;
    acc_seen = 1'b0;
    pop_seen = 1'b0;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back({{N{1'b0}}, a} * {{N{1'b0}}, b});
        acc_seen = 1'b1;
      end
      if (out_valid && out_ready) begin
        pop_seen = 1'b1;
        if (exp_q.size() == 0) begin
          check("sb_unexpected_output", product, '0);
          check("sb_queue_nonempty", 64'd0, 64'd1);
        end else begin
          expv = exp_q.pop_front();
          check("sb_product", product, expv);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  // Accept one operand pair, check the fixed latency and the constant product,
  // consume it, and confirm in_ready comes back on the following cycle.
  task automatic run_op(input string tag, input logic [N-1:0] va, input logic [N-1:0] vb,
                        input logic [2*N-1:0] expp);
    int lat;
    a = va;
    b = vb;
    in_valid = 1'b1;
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      cycle();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(N + 1));
    check({tag, "_product"}, product, expp);
    check({tag, "_in_ready_in_done"}, 64'(in_ready), 64'd0);
    cycle();
    check({tag, "_in_ready_after"}, 64'(in_ready), 64'd1);
    check({tag, "_out_valid_after"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int lat;
    int seen_valid;
    int sent;
    int recv;
    int budget;
    logic [2*N-1:0] hold_exp;

    tests = 0;
    fails = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;

    do_reset();
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_product", product, '0);
    check("reset_state", 64'(dbg_state), 64'd0);

    // basic and carry-path cases
    run_op("mul_3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F);
    run_op("mul_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_op("mul_a0", 32'd0, 32'h1234_5678, 64'd0);
    run_op("mul_b0", 32'hDEAD_BEEF, 32'd0, 64'd0);
    run_op("mul_one", 32'd1, 32'h8000_0001, 64'h0000_0000_8000_0001);

    // backpressure, with operand noise during BUSY and DONE
    a = 32'h1234_5678;
    b = 32'h9ABC_DEF0;
    hold_exp = 64'h0B00_EA4E_242D_2080;
    in_valid = 1'b1;
    out_ready = 1'b0;
    cycle();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      in_valid = (lat % 3 == 0);
      a = $urandom;
      b = $urandom;
      cycle();
      lat++;
    end
    check("bp_latency", 64'(lat), 64'(N + 1));
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      a = $urandom;
      b = $urandom;
      cycle();
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_product", product, hold_exp);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cycle();
    check("bp_consumed", 64'(pop_seen), 64'd1);
    check("bp_idle_after", 64'(in_ready), 64'd1);
    check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // reset in the middle of an operation
    a = 32'hDEAD_0001;
    b = 32'hBEEF_0003;
    in_valid = 1'b1;
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 15; i++) cycle();
    check("abort_in_busy", 64'(dbg_state), 64'd1);
    rst = 1'b1;
    in_valid = 1'b1;
    cycle();
    rst = 1'b0;
    in_valid = 1'b0;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_product", product, '0);
    seen_valid = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (out_valid) seen_valid++;
    end
    check("abort_no_out_valid", 64'(seen_valid), 64'd0);
    run_op("mul_7x6", 32'd7, 32'd6, 64'd42);

    // back-to-back random traffic, in_valid held high
    sent = 0;
    recv = 0;
    budget = 0;
    a = $urandom;
    b = $urandom;
    while (recv < 100 && budget < 20000) begin
      in_valid = (sent < 100);
      out_ready = $urandom_range(0, 1);
      cycle();
      budget++;
      if (pop_seen) recv++;
      if (acc_seen) begin
        sent++;
        case ($urandom_range(0, 5))
          0: a = '1;
          1: a = '0;
          default: a = $urandom;
        endcase
        case ($urandom_range(0, 5))
          0: b = '1;
          1: b = 32'd1;
          default: b = $urandom;
        endcase
      end
    end
    in_valid = 1'b0;
    check("rand_sent", 64'(sent), 64'd100);
    check("rand_recv", 64'(recv), 64'd100);
    check("rand_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
